// File: rtl/digit_overlay.sv
// Seven-segment clock overlay: draws NUM_DIGITS BCD digits with blinking colons over active video.
// Optional macro OVERLAY_BLINK_EN enables the colon blink counter; without it colons stay lit.
module digit_overlay #(
    parameter int NUM_DIGITS   = 6,
    parameter int BLOCK_SIZE   = 5,
    parameter int DIGIT_GAP    = 20,
    parameter int ORIGIN_X     = 200,
    parameter int ORIGIN_Y     = 340,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    h_disp,
    input  logic                    v_disp,
    input  logic [10:0]             pix_x,
    input  logic [10:0]             pix_y,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic                    frame_start,
    output logic                    r_out,
    output logic                    g_out,
    output logic                    b_out
);

    localparam int DIGIT_W   = 5 * BLOCK_SIZE;
    localparam int DIGIT_H   = 9 * BLOCK_SIZE;
    localparam int PITCH     = DIGIT_W + DIGIT_GAP;
    localparam int COLON_OFS = DIGIT_W + (DIGIT_GAP - BLOCK_SIZE) / 2;

    // Segment bits ordered {g,f,e,d,c,b,a}; non-decimal codes stay dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] segs;
        case (nib)
            4'd0:    segs = 7'b0111111;
            4'd1:    segs = 7'b0000110;
            4'd2:    segs = 7'b1011011;
            4'd3:    segs = 7'b1001111;
            4'd4:    segs = 7'b1100110;
            4'd5:    segs = 7'b1101101;
            4'd6:    segs = 7'b1111101;
            4'd7:    segs = 7'b0000111;
            4'd8:    segs = 7'b1111111;
            4'd9:    segs = 7'b1101111;
            default: segs = 7'b0000000;
        endcase
        return segs;
    endfunction

    function automatic logic [6:0] cell_mask(input logic [2:0] col, input logic [3:0] row);
        logic [6:0] mask;
        logic       mid_col;
        mid_col = (col >= 3'd1) && (col <= 3'd3);
        mask[0] = mid_col && (row == 4'd0);
        mask[1] = (col == 3'd4) && (row >= 4'd1) && (row <= 4'd3);
        mask[2] = (col == 3'd4) && (row >= 4'd5) && (row <= 4'd7);
        mask[3] = mid_col && (row == 4'd8);
        mask[4] = (col == 3'd0) && (row >= 4'd5) && (row <= 4'd7);
        mask[5] = (col == 3'd0) && (row >= 4'd1) && (row <= 4'd3);
        mask[6] = mid_col && (row == 4'd4);
        return mask;
    endfunction

    logic [4*NUM_DIGITS-1:0] snap_r;
    logic                    colon_vis_s;
    int                      px_s, py_s, dx_s, dy_s;
    logic                    in_rows_s, hit_k_s, dig_hit_s, colon_hit_s;
    logic [2:0]              dig_idx_s, col_s;
    logic [3:0]              row_s;
    logic                    act_r, dig_hit_r, colon_hit_r;
    logic [2:0]              dig_idx_r, col_r;
    logic [3:0]              row_r;
    logic [3:0]              nib_s;
    logic                    lit_s;
    logic [2:0]              rgb_s;

    // Frame snapshot of the displayed digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            snap_r <= '0;
        end else if (frame_start) begin
            snap_r <= digits;
        end
    end

`ifdef OVERLAY_BLINK_EN
    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    logic [CNT_W-1:0] frame_cnt_r;
    logic             colon_vis_r;

    // Frame counter; colon visibility flips each time it wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_r <= '0;
            colon_vis_r <= 1'b1;
        end else if (frame_start) begin
            if (frame_cnt_r == CNT_W'(BLINK_FRAMES - 1)) begin
                frame_cnt_r <= '0;
                colon_vis_r <= ~colon_vis_r;
            end else begin
                frame_cnt_r <= frame_cnt_r + CNT_W'(1);
            end
        end
    end

    assign colon_vis_s = colon_vis_r;
`else
    assign colon_vis_s = 1'b1;
`endif

    // Stage 1 decode: signed int arithmetic so out-of-box pixels never wrap into a box.
    always_comb begin
        px_s        = int'({21'd0, pix_x});
        py_s        = int'({21'd0, pix_y});
        dy_s        = py_s - ORIGIN_Y;
        in_rows_s   = (dy_s >= 0) && (dy_s < DIGIT_H);
        dig_hit_s   = 1'b0;
        dig_idx_s   = 3'd0;
        dx_s        = 0;
        colon_hit_s = 1'b0;
        hit_k_s     = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hit_k_s     = in_rows_s && (px_s >= ORIGIN_X + k * PITCH)
                          && (px_s < ORIGIN_X + k * PITCH + DIGIT_W);
            dig_hit_s   = dig_hit_s | hit_k_s;
            dig_idx_s   = hit_k_s ? 3'(k) : dig_idx_s;
            dx_s        = hit_k_s ? (px_s - (ORIGIN_X + k * PITCH)) : dx_s;
            colon_hit_s = colon_hit_s | (((k % 2) == 1) && (k < NUM_DIGITS - 1)
                          && (px_s >= ORIGIN_X + k * PITCH + COLON_OFS)
                          && (px_s < ORIGIN_X + k * PITCH + COLON_OFS + BLOCK_SIZE)
                          && (((dy_s >= 2 * BLOCK_SIZE) && (dy_s < 4 * BLOCK_SIZE))
                           || ((dy_s >= 5 * BLOCK_SIZE) && (dy_s < 7 * BLOCK_SIZE))));
        end
        col_s = 3'(dx_s / BLOCK_SIZE);
        row_s = in_rows_s ? 4'(dy_s / BLOCK_SIZE) : 4'd0;
    end

    // Stage 1 registers: hit flags, digit index and local cell.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_r       <= 1'b0;
            dig_hit_r   <= 1'b0;
            colon_hit_r <= 1'b0;
            dig_idx_r   <= 3'd0;
            col_r       <= 3'd0;
            row_r       <= 4'd0;
        end else begin
            act_r       <= h_disp & v_disp;
            dig_hit_r   <= dig_hit_s;
            colon_hit_r <= colon_hit_s;
            dig_idx_r   <= dig_idx_s;
            col_r       <= col_s;
            row_r       <= row_s;
        end
    end

    // Stage 2 colour selection from the snapshot nibble of the hit digit.
    always_comb begin
        nib_s = 4'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            nib_s = (dig_idx_r == 3'(k)) ? snap_r[4*(NUM_DIGITS-1-k) +: 4] : nib_s;
        end
        lit_s = (dig_hit_r && (|(seg_decode(nib_s) & cell_mask(col_r, row_r))))
                || (colon_hit_r && colon_vis_s);
        if (!act_r) begin
            rgb_s = 3'b000;
        end else if (lit_s) begin
            rgb_s = 3'b110;
        end else begin
            rgb_s = 3'b001;
        end
    end

    // Stage 2 registered colour outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out <= 1'b0;
            g_out <= 1'b0;
            b_out <= 1'b0;
        end else begin
            r_out <= rgb_s[2];
            g_out <= rgb_s[1];
            b_out <= rgb_s[0];
        end
    end

endmodule

// File: tb/tb_digit_overlay.sv
// Self-checking bench for digit_overlay: a pixel-rectangle reference model checked every cycle,
// plus directed probes with hand-computed colours. Blink probes run only with OVERLAY_BLINK_EN.
module tb_digit_overlay;

    localparam int N = 6, B = 5, G = 20, OX = 200, OY = 340, BF = 30;
    localparam logic [2:0] YEL = 3'b110, BLU = 3'b001, BLK = 3'b000;

    logic        clk = 1'b0, rst = 1'b1;
    logic        h_disp = 1'b0, v_disp = 1'b0, frame_start = 1'b0;
    logic [10:0] pix_x = 11'd0, pix_y = 11'd0;
    logic [23:0] digits = 24'h000000;
    logic        r_out, g_out, b_out;

    int checks = 0;
    int errors = 0;

    digit_overlay dut (
        .clk(clk), .rst(rst), .h_disp(h_disp), .v_disp(v_disp),
        .pix_x(pix_x), .pix_y(pix_y), .digits(digits), .frame_start(frame_start),
        .r_out(r_out), .g_out(g_out), .b_out(b_out)
    );

    always #5 clk = ~clk;

    function automatic string seg_pattern(input logic [3:0] d);
        case (d)
            4'd0: return "abcdef";
            4'd1: return "bc";
            4'd2: return "abdeg";
            4'd3: return "abcdg";
            4'd4: return "bcfg";
            4'd5: return "acdfg";
            4'd6: return "acdefg";
            4'd7: return "abc";
            4'd8: return "abcdefg";
            4'd9: return "abcdfg";
            default: return "";
        endcase
    endfunction

    function automatic bit in_rect(int x, int y, int x0, int y0, int w, int h);
        return (x >= x0) && (x < x0 + w) && (y >= y0) && (y < y0 + h);
    endfunction

    // Reference colour: each lit segment and colon dot as a pixel rectangle.
    function automatic logic [2:0] model_rgb(int x, int y, bit h, bit v, logic [23:0] snap, bit vis);
        string pat;
        byte   c;
        int    xk, cs, rs, w, hh;
        if (!(h && v)) return BLK;
        for (int k = 0; k < N; k++) begin
            xk  = OX + k * (5 * B + G);
            pat = seg_pattern(snap[4*(N-1-k) +: 4]);
            for (int i = 0; i < pat.len(); i++) begin
                c = pat.getc(i);
                case (c)
                    "a": begin cs = 1; rs = 0; w = 3; hh = 1; end
                    "b": begin cs = 4; rs = 1; w = 1; hh = 3; end
                    "c": begin cs = 4; rs = 5; w = 1; hh = 3; end
                    "d": begin cs = 1; rs = 8; w = 3; hh = 1; end
                    "e": begin cs = 0; rs = 5; w = 1; hh = 3; end
                    "f": begin cs = 0; rs = 1; w = 1; hh = 3; end
                    default: begin cs = 1; rs = 4; w = 3; hh = 1; end
                endcase
                if (in_rect(x, y, xk + cs * B, OY + rs * B, w * B, hh * B)) return YEL;
            end
            if (vis && (k % 2 == 1) && (k < N - 1)) begin
                if (in_rect(x, y, xk + 5 * B + (G - B) / 2, OY + 2 * B, B, 2 * B) ||
                    in_rect(x, y, xk + 5 * B + (G - B) / 2, OY + 5 * B, B, 2 * B)) return YEL;
            end
        end
        return BLU;
    endfunction

    logic [23:0] m_snap = 24'h000000;
    bit          m_vis = 1'b1;
    logic [2:0]  exp_s1 = BLK, exp_out = BLK;
`ifdef OVERLAY_BLINK_EN
    int          m_cnt = 0;
`endif

    // Model state follows frame_start; expected colour trails the pixel by two edges.
    always @(posedge clk or posedge rst) begin : mdl
        logic [23:0] ns;
        bit          nv;
        if (rst) begin
            m_snap  <= 24'h000000;
            m_vis   <= 1'b1;
            exp_s1  <= BLK;
            exp_out <= BLK;
`ifdef OVERLAY_BLINK_EN
            m_cnt   <= 0;
`endif
        end else begin
            ns = m_snap;
            nv = m_vis;
            if (frame_start) begin
                ns = digits;
`ifdef OVERLAY_BLINK_EN
                if (m_cnt + 1 == BF) begin
                    m_cnt <= 0;
                    nv = !nv;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
`endif
            end
            m_snap  <= ns;
            m_vis   <= nv;
            exp_out <= exp_s1;
            exp_s1  <= model_rgb(int'(pix_x), int'(pix_y), h_disp, v_disp, ns, nv);
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({r_out, g_out, b_out} !== exp_out) begin
                errors++;
                $display("FAIL stream t=%0t rgb=%b expected=%b", $time, {r_out, g_out, b_out}, exp_out);
            end
        end
    end

    task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s rgb=%b expected=%b", name, got, want);
        end
    endtask

    task automatic drive(input int x, input int y, input bit h, input bit v);
        pix_x  = 11'(x);
        pix_y  = 11'(y);
        h_disp = h;
        v_disp = v;
    endtask

    task automatic probe(input string name, input int x, input int y, input logic [2:0] want);
        drive(x, y, 1'b1, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check(name, {r_out, g_out, b_out}, want);
    endtask

    task automatic pulse(input logic [23:0] d);
        digits      = d;
        frame_start = 1'b1;
        @(posedge clk); #1;
        frame_start = 1'b0;
    endtask

    task automatic scan(input int x0, input int x1, input int y0, input int y1, input int ystep);
        for (int y = y0; y <= y1; y += ystep) begin
            for (int x = x0; x <= x1; x++) begin
                drive(x, y, 1'b1, 1'b1);
                @(posedge clk); #1;
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", {r_out, g_out, b_out}, BLK);
        rst = 1'b0;

        probe("rst_seg_a", 210, 342, YEL);
        probe("rst_seg_b", 222, 350, YEL);
        probe("rst_seg_g", 212, 360, BLU);
        probe("colon_on", 279, 352, YEL);
        probe("colon_gap", 279, 362, BLU);

        pulse(24'h123456);
        probe("one_b", 222, 350, YEL);
        probe("one_a", 210, 342, BLU);
        probe("three_e", 291, 370, BLU);
        probe("three_g", 300, 362, YEL);
        probe("right_edge_in", 224, 350, YEL);
        probe("right_edge_out", 225, 350, BLU);
        probe("six_d", 435, 384, YEL);
        probe("below_box", 435, 385, BLU);
        probe("left_of_origin", 199, 342, BLU);
        probe("origin_0_0", 0, 0, BLU);
        probe("far_corner", 2047, 2047, BLU);
        probe("colon_left", 277, 350, YEL);
        probe("colon_left_out", 276, 350, BLU);
        probe("colon_bot", 281, 374, YEL);
        probe("colon_right_out", 282, 374, BLU);
        probe("colon_below", 281, 375, BLU);
        probe("colon3", 367, 367, YEL);
        probe("no_colon5", 457, 352, BLU);

        drive(222, 350, 1'b0, 1'b1);
        @(posedge clk); #1; @(posedge clk); #1;
        check("hdisp_off", {r_out, g_out, b_out}, BLK);
        drive(222, 350, 1'b1, 1'b0);
        @(posedge clk); #1; @(posedge clk); #1;
        check("vdisp_off", {r_out, g_out, b_out}, BLK);

        digits = 24'h000000;
        probe("stale_b", 222, 350, YEL);
        probe("stale_a", 210, 342, BLU);
        pulse(24'h000000);
        probe("fresh_a", 210, 342, YEL);

        pulse(24'hA00000);
        probe("blank_b", 222, 350, BLU);
        probe("blank_a", 210, 342, BLU);
        scan(200, 224, 340, 384, 1);

        pulse(24'h789012);
        scan(190, 480, 336, 388, 2);
        pulse(24'h345678);
        scan(190, 480, 337, 389, 2);

        pulse(24'h123456);
        drive(222, 350, 1'b1, 1'b1);
        @(posedge clk); #1; @(posedge clk); #1;
        check("pre_reset", {r_out, g_out, b_out}, YEL);
        #2 rst = 1'b1;
        #1 check("async_reset", {r_out, g_out, b_out}, BLK);
        @(posedge clk); #1;
        rst = 1'b0;
        probe("post_rst_a", 210, 342, YEL);
        probe("post_rst_b", 222, 350, YEL);
        probe("post_rst_g", 212, 360, BLU);

`ifdef OVERLAY_BLINK_EN
        repeat (BF - 1) pulse(24'h000000);
        probe("blink_29", 279, 352, YEL);
        pulse(24'h000000);
        probe("blink_30", 279, 352, BLU);
        repeat (BF) pulse(24'h000000);
        probe("blink_60", 279, 352, YEL);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
